// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory-side bus responder.
package mem_bus_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 10;
   localparam int WAIT_W     = 4;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      RWAIT,
      RDRIVE,
      WHOLD
   } resp_state_t;

endpackage

// File: rtl/responder_ram.sv
// Single-port synchronous RAM with registered read and no reset; read returns old data on a same-edge write.
module responder_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
) (
   input  logic              Clock,
   input  logic              We,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] Wd,
   output logic [DATA_W-1:0] Rd
);

   logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

   always_ff @(posedge Clock) begin
      if (We) begin
         r_mem[Addr] <= Wd;
      end
      Rd <= r_mem[Addr];
   end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side target of the multiplexed AD bus: latches an address on ALE, then
// services one read or one write to the internal RAM per bus cycle.
module mem_bus_responder
   import mem_bus_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int WAIT_STATES = 0
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              ALE,
   input  logic              nME,
   input  logic              nOE,
   input  logic              nWE,
   input  logic [DATA_W-1:0] BusIn,
   output logic [DATA_W-1:0] BusOut,
   output logic              BusOe,
   output logic              Rdy,
   output logic              Err
);

   resp_state_t       r_state;
   resp_state_t       w_nextState;
   logic [ADDR_W-1:0] r_addr;
   logic [WAIT_W-1:0] r_waitCnt;
   logic [DATA_W-1:0] r_busOut;
   logic              r_busOe;
   logic              r_err;
   logic [DATA_W-1:0] w_ramRd;
   logic              w_relatch;
   logic              w_we;
   logic              w_setErr;
   logic              w_loadCnt;
   logic              w_drive;

   // ALE with a select aborts whatever is in progress, from any state.
   assign w_relatch = ALE & ~nME;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      if (w_relatch) begin
         w_nextState = ADDR;
      end else begin
         case (r_state)
            IDLE:    w_nextState = IDLE;
            ADDR: begin
               if (nME)               w_nextState = IDLE;
               else if (!nOE && !nWE) w_nextState = IDLE;
               else if (!nOE)         w_nextState = RWAIT;
               else if (!nWE)         w_nextState = WHOLD;
            end
            RWAIT: begin
               if (nME || nOE)             w_nextState = IDLE;
               else if (r_waitCnt == '0)   w_nextState = RDRIVE;
            end
            RDRIVE:  if (nME || nOE) w_nextState = IDLE;
            WHOLD:   if (nME || nWE) w_nextState = IDLE;
            default: w_nextState = IDLE;
         endcase
      end
   end

   always_comb begin
      w_we      = 1'b0;
      w_setErr  = 1'b0;
      w_loadCnt = 1'b0;
      w_drive   = 1'b0;
      if (!w_relatch && !nME) begin
         if (r_state == ADDR) begin
            w_setErr  = ~nOE & ~nWE;
            w_loadCnt = ~nOE &  nWE;
            w_we      =  nOE & ~nWE & ~Reset;
         end
         if (r_state == RWAIT) begin
            w_drive = ~nOE & (r_waitCnt == '0);
         end
      end
   end

   // The count starts one above WAIT_STATES so the registered RAM read has settled before BusOut loads.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_addr    <= '0;
         r_waitCnt <= '0;
         r_busOut  <= '0;
         r_busOe   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (w_relatch) begin
            r_addr <= BusIn[ADDR_W-1:0];
         end
         if (w_loadCnt) begin
            r_waitCnt <= WAIT_W'(WAIT_STATES + 1);
         end else if (r_state == RWAIT && r_waitCnt != '0) begin
            r_waitCnt <= r_waitCnt - 1'b1;
         end
         if (w_drive) begin
            r_busOut <= w_ramRd;
         end
         r_busOe <= (w_nextState == RDRIVE);
         if (w_setErr) begin
            r_err <= 1'b1;
         end
      end
   end

   responder_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .Clock (Clock),
      .We    (w_we),
      .Addr  (r_addr),
      .Wd    (BusIn),
      .Rd    (w_ramRd)
   );

   assign BusOut = r_busOut;
   assign BusOe  = r_busOe;
   assign Rdy    = r_busOe;
   assign Err    = r_err;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Drives two responders (0 and 3 wait states) with the same bus traffic and checks
// them against a transaction-level memory model.
module tb_mem_bus_responder;

   logic        clock;
   logic        reset;
   logic        ale;
   logic        nMe;
   logic        nOe;
   logic        nWe;
   logic [15:0] busIn;
   logic [15:0] busOut0, busOut3;
   logic        busOe0, busOe3;
   logic        rdy0, rdy3;
   logic        err0, err3;

   int          nChecks;
   int          nFails;
   logic [15:0] model [int];
   int          written [$];

   mem_bus_responder #(.DATA_W(16), .ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
      .Clock(clock), .Reset(reset), .ALE(ale), .nME(nMe), .nOE(nOe), .nWE(nWe),
      .BusIn(busIn), .BusOut(busOut0), .BusOe(busOe0), .Rdy(rdy0), .Err(err0)
   );

   mem_bus_responder #(.DATA_W(16), .ADDR_W(10), .WAIT_STATES(3)) u_dut3 (
      .Clock(clock), .Reset(reset), .ALE(ale), .nME(nMe), .nOE(nOe), .nWE(nWe),
      .BusIn(busIn), .BusOut(busOut3), .BusOe(busOe3), .Rdy(rdy3), .Err(err3)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic a, input logic me, input logic oe,
                                input logic we, input logic [15:0] bus);
      ale   = a;
      nMe   = me;
      nOe   = oe;
      nWe   = we;
      busIn = bus;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      nChecks++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic checkQuiet(input string tag);
      checkBit({tag, "_oe0"}, busOe0, 1'b0);
      checkBit({tag, "_oe3"}, busOe3, 1'b0);
      checkBit({tag, "_rdy0"}, rdy0, 1'b0);
      checkBit({tag, "_rdy3"}, rdy3, 1'b0);
   endtask

   task automatic doWrite(input logic [15:0] busAddr, input logic [15:0] data);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, busAddr);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, data);
      tick();
      model[int'(busAddr[9:0])] = data;
      written.push_back(int'(busAddr[9:0]));
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
      tick();
   endtask

   // Starts with the responders in the address phase; nOE goes low at edge k.
   task automatic readBody(input int key, input bit resetAtEnd);
      logic [15:0] expData;
      expData = model.exists(key) ? model[key] : 16'h0000;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      tick();
      checkQuiet("rd_k");
      for (int i = 1; i <= 6; i++) begin
         tick();
         checkBit("rd_oe0", busOe0, i >= 2);
         checkBit("rd_rdy0", rdy0, i >= 2);
         checkBit("rd_oe3", busOe3, i >= 5);
         checkBit("rd_rdy3", rdy3, i >= 5);
         if (i >= 2) checkOutput("rd_data0", busOut0, expData);
         if (i >= 5) checkOutput("rd_data3", busOut3, expData);
      end
      if (resetAtEnd) begin
         reset = 1'b1;
         tick();
         reset = 1'b0;
         checkQuiet("rst_rdrive");
         checkOutput("rst_out0", busOut0, 16'h0000);
         checkOutput("rst_out3", busOut3, 16'h0000);
         checkBit("rst_err0", err0, 1'b0);
      end else begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
         tick();
         checkQuiet("rd_release");
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
      tick();
   endtask

   task automatic doRead(input logic [15:0] busAddr);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, busAddr);
      tick();
      readBody(int'(busAddr[9:0]), 1'b0);
   endtask

   initial begin
      logic [15:0] addr;
      logic [15:0] data;
      int          key;
      nChecks = 0;
      nFails  = 0;
      reset   = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
      tick();
      tick();
      checkQuiet("reset");
      checkOutput("reset_out0", busOut0, 16'h0000);
      checkOutput("reset_out3", busOut3, 16'h0000);
      checkBit("reset_err0", err0, 1'b0);
      checkBit("reset_err3", err3, 1'b0);
      reset = 1'b0;
      tick();

      $display("[TB] basic write then read");
      doWrite(16'h0012, 16'hBEEF);
      doRead(16'h0012);

      $display("[TB] ALE during RWAIT relatches");
      doWrite(16'h03FF, 16'hA5A5);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h0012);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h03FF);
      tick();
      checkQuiet("abort_relatch");
      readBody(16'h03FF, 1'b0);

      $display("[TB] address wrap");
      doWrite(16'hFC05, 16'h1357);
      doRead(16'h0005);

      $display("[TB] deselected bus activity");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h0012);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'hDEAD);
      tick();
      checkQuiet("nme_high");
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
      tick();
      doRead(16'h0012);

      $display("[TB] nOE released during RWAIT");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h0005);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
      for (int i = 0; i < 6; i++) begin
         tick();
         checkQuiet("rwait_abort");
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
      tick();

      $display("[TB] reset discards same-edge write");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h0012);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h1234);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
      tick();
      doRead(16'h0012);

      $display("[TB] protocol error");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h03FF);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h7777);
      tick();
      checkBit("err_set0", err0, 1'b1);
      checkBit("err_set3", err3, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
      tick();
      doRead(16'h03FF);
      doWrite(16'h0100, 16'h4242);
      checkBit("err_hold0", err0, 1'b1);
      checkBit("err_hold3", err3, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkBit("err_clr0", err0, 1'b0);
      checkBit("err_clr3", err3, 1'b0);

      $display("[TB] reset during RDRIVE");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h0012);
      tick();
      readBody(16'h0012, 1'b1);
      doRead(16'h0012);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 24; n++) begin
         if (written.size() == 0 || $urandom_range(1, 0) == 0) begin
            addr = 16'($urandom_range(16'hFFFF, 0));
            data = 16'($urandom_range(16'hFFFF, 0));
            doWrite(addr, data);
         end else begin
            key  = written[$urandom_range(written.size() - 1, 0)];
            addr = {6'($urandom_range(63, 0)), key[9:0]};
            doRead(addr);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
